// File: rtl/systolic_skew_feeder_if.sv
// Row-write port, stream control and skewed west/north feeds of the systolic skew feeder.
// The master side loads rows and starts streams; the slave side is the feeder itself.
interface systolic_skew_feeder_if #(
  parameter int SIZE       = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic                       wr_valid;
  logic                       wr_ready;
  logic                       wr_sel;
  logic [ROW_W-1:0]           wr_row;
  logic [SIZE*DATA_WIDTH-1:0] wr_data;
  logic                       start;
  logic                       busy;
  logic [SIZE*DATA_WIDTH-1:0] inp_west;
  logic [SIZE*DATA_WIDTH-1:0] inp_north;
  logic                       feed_valid;
  logic                       feed_done;

  modport master (
    output wr_valid, wr_sel, wr_row, wr_data, start,
    input  wr_ready, busy, inp_west, inp_north, feed_valid, feed_done
  );

  modport slave (
    input  wr_valid, wr_sel, wr_row, wr_data, start,
    output wr_ready, busy, inp_west, inp_north, feed_valid, feed_done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers two SIZExSIZE tiles and streams them diagonally skewed into a systolic array, 1 cycle after start.
// Writes are only accepted while idle (wr_ready low during a stream); start outside IDLE is ignored.
module systolic_skew_feeder #(
  parameter int SIZE       = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CNT_W = $clog2(3*SIZE + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(3*SIZE - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           slot_nxt;
  logic                       wr_acc;
  logic [DATA_WIDTH-1:0]      a_buf [SIZE][SIZE];
  logic [DATA_WIDTH-1:0]      b_buf [SIZE][SIZE];
  logic [DATA_WIDTH-1:0]      a_eff [SIZE][SIZE];
  logic [DATA_WIDTH-1:0]      b_eff [SIZE][SIZE];
  logic [SIZE*DATA_WIDTH-1:0] west_q;
  logic [SIZE*DATA_WIDTH-1:0] north_q;
  logic [SIZE*DATA_WIDTH-1:0] west_nxt;
  logic [SIZE*DATA_WIDTH-1:0] north_nxt;

  assign wr_acc = bus.wr_valid && (state == IDLE) && (int'(bus.wr_row) < SIZE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = STREAM;
      STREAM:  if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.wr_ready   = (state == IDLE);
    bus.busy       = (state != IDLE);
    bus.feed_valid = (state == STREAM);
    bus.feed_done  = (state == DONE);
  end

  assign bus.inp_west  = west_q;
  assign bus.inp_north = north_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (wr_acc) begin
      for (int r = 0; r < SIZE; r++) begin
        if (bus.wr_row == ROW_W'(r)) begin
          for (int c = 0; c < SIZE; c++) begin
            if (!bus.wr_sel) a_buf[r][c] <= bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH];
            else             b_buf[r][c] <= bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Write bypass: a row written on the same edge that samples start must already feed slot 0.
  always_comb begin
    a_eff = a_buf;
    b_eff = b_buf;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (wr_acc && bus.wr_row == ROW_W'(r)) begin
          if (!bus.wr_sel) a_eff[r][c] = bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH];
          else             b_eff[r][c] = bus.wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign slot_nxt = (state == STREAM) ? cnt + CNT_W'(1) : '0;

  // Lane i carries element k = t - i; west reads A row-wise, north reads B column-wise.
  always_comb begin
    west_nxt  = '0;
    north_nxt = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (int'(slot_nxt) == i + k) begin
          west_nxt[i*DATA_WIDTH +: DATA_WIDTH]  = a_eff[i][k];
          north_nxt[i*DATA_WIDTH +: DATA_WIDTH] = b_eff[k][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      west_q  <= '0;
      north_q <= '0;
    end else if (state_nxt == STREAM) begin
      cnt     <= slot_nxt;
      west_q  <= west_nxt;
      north_q <= north_nxt;
    end else begin
      cnt     <= '0;
      west_q  <= '0;
      north_q <= '0;
    end
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: scoreboarded streams plus a table of spot values.
module tb_systolic_skew_feeder;
  localparam int S     = 6;
  localparam int DW    = 32;
  localparam int NSLOT = 3*S;

  typedef logic [S*DW-1:0] vec_t;
  typedef struct { vec_t west; vec_t north; } slot_t;
  typedef struct { int slot; int lane; bit is_north; logic [DW-1:0] val; } spot_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.SIZE(S), .DATA_WIDTH(DW)) bus ();
  systolic_skew_feeder #(.SIZE(S), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ma [S][S];
  logic [DW-1:0] mb [S][S];
  slot_t sb_q [$];
  vec_t  cap_w [NSLOT];
  vec_t  cap_n [NSLOT];
  spot_t spots [$];

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t exp_west(input int s);
    vec_t v = '0;
    for (int i = 0; i < S; i++) begin
      int k;
      k = s - i;
      if (k >= 0 && k < S) v[i*DW +: DW] = ma[i][k];
    end
    return v;
  endfunction

  function automatic vec_t exp_north(input int s);
    vec_t v = '0;
    for (int j = 0; j < S; j++) begin
      int k;
      k = s - j;
      if (k >= 0 && k < S) v[j*DW +: DW] = mb[k][j];
    end
    return v;
  endfunction

  function automatic vec_t row_vec(input bit sel, input int r);
    vec_t v = '0;
    for (int c = 0; c < S; c++) v[c*DW +: DW] = sel ? mb[r][c] : ma[r][c];
    return v;
  endfunction

  task automatic idle_inputs();
    bus.wr_valid = 1'b0;
    bus.wr_sel   = 1'b0;
    bus.wr_row   = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
  endtask

  task automatic write_row(input bit sel, input int row, input vec_t data);
    bus.wr_valid = 1'b1;
    bus.wr_sel   = sel;
    bus.wr_row   = 3'(row);
    bus.wr_data  = data;
    check("wr_ready_idle", bus.wr_ready, 1);
    if (row < S) begin
      for (int c = 0; c < S; c++) begin
        if (sel) mb[row][c] = data[c*DW +: DW];
        else     ma[row][c] = data[c*DW +: DW];
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Entered on a falling edge with the DUT idle; leaves one cycle after feed_done.
  task automatic run_stream(input bit inject, input bit prewrite, input vec_t pw_data);
    int nslot;
    int ndone;
    int budget;
    slot_t e;
    nslot = 0;
    ndone = 0;
    budget = 0;
    if (prewrite) begin
      bus.wr_valid = 1'b1;
      bus.wr_sel   = 1'b0;
      bus.wr_row   = '0;
      bus.wr_data  = pw_data;
      for (int c = 0; c < S; c++) ma[0][c] = pw_data[c*DW +: DW];
    end
    bus.start = 1'b1;
    for (int s = 0; s < NSLOT; s++) sb_q.push_back('{exp_west(s), exp_north(s)});
    @(negedge clk);
    idle_inputs();
    while ((sb_q.size() > 0 || ndone == 0) && budget < 4*NSLOT) begin
      idle_inputs();
      if (bus.feed_valid) begin
        if (sb_q.size() == 0) begin
          check("extra_slot", bus.feed_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("slot%0d_west", nslot), bus.inp_west, e.west);
          check($sformatf("slot%0d_north", nslot), bus.inp_north, e.north);
          check("busy_stream", bus.busy, 1);
          if (nslot < NSLOT) begin
            cap_w[nslot] = bus.inp_west;
            cap_n[nslot] = bus.inp_north;
          end
        end
        nslot++;
        if (inject && nslot == 5) begin
          bus.start    = 1'b1;
          bus.wr_valid = 1'b1;
          bus.wr_sel   = 1'b0;
          bus.wr_row   = '0;
          bus.wr_data  = {S{32'd99}};
          check("wr_ready_stream", bus.wr_ready, 0);
        end
      end
      if (bus.feed_done) begin
        ndone++;
        check("done_west_zero", bus.inp_west, '0);
        check("done_north_zero", bus.inp_north, '0);
        check("done_after_last_slot", sb_q.size(), 0);
        check("done_busy", bus.busy, 1);
      end
      @(negedge clk);
      budget++;
    end
    if (budget >= 4*NSLOT) begin
      errors++;
      $display("FAIL stream_timeout: got %0d slots %0d done, required %0d slots 1 done", nslot, ndone, NSLOT);
    end
    sb_q.delete();
    check("feed_valid_cycles", nslot, NSLOT);
    check("done_single_cycle", bus.feed_done, 0);
    check("idle_after_done", bus.busy, 0);
    check("wr_ready_after_done", bus.wr_ready, 1);
  endtask

  task automatic check_spots(input string tag);
    for (int n = 0; n < spots.size(); n++) begin
      vec_t v;
      v = spots[n].is_north ? cap_n[spots[n].slot] : cap_w[spots[n].slot];
      if (spots[n].lane < 0)
        check($sformatf("%s_s%0d_%s_all", tag, spots[n].slot, spots[n].is_north ? "n" : "w"), v, '0);
      else
        check($sformatf("%s_s%0d_%s%0d", tag, spots[n].slot, spots[n].is_north ? "n" : "w", spots[n].lane),
              v[spots[n].lane*DW +: DW], spots[n].val);
    end
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_wr_ready"}, bus.wr_ready, 1);
    check({tag, "_feed_valid"}, bus.feed_valid, 0);
    check({tag, "_feed_done"}, bus.feed_done, 0);
    check({tag, "_west"}, bus.inp_west, '0);
    check({tag, "_north"}, bus.inp_north, '0);
  endtask

  initial begin
    spots.push_back('{0, 0, 1'b0, 32'd1});
    spots.push_back('{0, 1, 1'b0, 32'd0});
    spots.push_back('{0, 0, 1'b1, 32'd1});
    spots.push_back('{0, 5, 1'b1, 32'd0});
    spots.push_back('{5, 0, 1'b0, 32'd6});
    spots.push_back('{5, 5, 1'b0, 32'd31});
    spots.push_back('{5, 0, 1'b1, 32'd6});
    spots.push_back('{5, 5, 1'b1, 32'd6});
    spots.push_back('{7, 3, 1'b0, 32'd23});
    spots.push_back('{7, 2, 1'b1, 32'd18});
    spots.push_back('{10, 5, 1'b0, 32'd36});
    spots.push_back('{10, 5, 1'b1, 32'd36});
    spots.push_back('{11, -1, 1'b0, 32'd0});
    spots.push_back('{11, -1, 1'b1, 32'd0});
    spots.push_back('{17, -1, 1'b0, 32'd0});
    spots.push_back('{17, -1, 1'b1, 32'd0});

    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
    end

    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_outputs_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < S; r++) begin
      vec_t va;
      vec_t vb;
      for (int c = 0; c < S; c++) begin
        va[c*DW +: DW] = 32'(r*6 + c + 1);
        vb[c*DW +: DW] = 32'((r+1)*(c+1));
      end
      write_row(1'b0, r, va);
      write_row(1'b1, r, vb);
    end

    run_stream(1'b0, 1'b0, '0);
    check_spots("first");
    run_stream(1'b1, 1'b0, '0);
    run_stream(1'b0, 1'b0, '0);
    check_spots("replay");

    write_row(1'b0, 7, {S{32'd77}});
    run_stream(1'b0, 1'b1, {S{32'd50}});
    begin
      vec_t w0;
      w0 = cap_w[0];
      check("prewrite_slot0_west_lane0", w0[DW-1:0], 32'd50);
    end

    bus.start = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (7) @(negedge clk);
    check("midrst_slot7_valid", bus.feed_valid, 1);
    check("midrst_slot7_west", bus.inp_west, exp_west(7));
    rst = 1'b0;
    #1 check_outputs_reset("midrst");
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", bus.feed_done, 0);
      check("midrst_idle", bus.busy, 0);
    end
    run_stream(1'b0, 1'b0, '0);
    check("zero_stream_slot0_west", cap_w[0], '0);
    check("zero_stream_slot5_north", cap_n[5], '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter SIZE, default 6, array dimension (tile is SIZE x SIZE).
REQ-002 Parameter DATA_WIDTH, default 32, element width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  row-write request.
REQ-006 wr_ready  output  1  row write accepted when wr_valid&&wr_ready at rising edge.
REQ-007 wr_sel  input  1  0 = matrix A buffer, 1 = matrix B buffer.
REQ-008 wr_row  input  $clog2(SIZE)  row index of the write.
REQ-009 wr_data  input  SIZE*DATA_WIDTH  one full row; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 start  input  1  begin skewed stream; sampled only in IDLE.
REQ-011 busy  output  1  high in STREAM and DONE states.
REQ-012 inp_west  output  SIZE*DATA_WIDTH  lane i drives systolic row i; registered.
REQ-013 inp_north  output  SIZE*DATA_WIDTH  lane j drives systolic column j; registered.
REQ-014 feed_valid  output  1  high while a stream slot is being presented.
REQ-015 feed_done  output  1  single-cycle pulse after the last slot.

Function
REQ-016 Block SHALL hold two SIZE x SIZE buffers A and B of DATA_WIDTH elements.
REQ-017 States SHALL be IDLE, STREAM, DONE; IDLE->STREAM on start, STREAM->DONE after slot t=3*SIZE-1, DONE->IDLE unconditionally next cycle.
REQ-018 wr_ready SHALL equal 1 in IDLE, 0 otherwise; writes outside IDLE SHALL NOT modify buffers.
REQ-019 Accepted write SHALL store wr_data into row wr_row of the buffer chosen by wr_sel.
REQ-020 Accepted write with wr_row >= SIZE SHALL be dropped with no buffer change.
REQ-021 Write and start in the same IDLE cycle SHALL both take effect; the written row SHALL appear in the stream.
REQ-022 Slot counter t SHALL run 0..3*SIZE-1, one slot per cycle; slot t SHALL be visible on outputs in the cycle after the edge that computed it; slot 0 appears in the cycle after the edge sampling start (1-cycle latency).
REQ-023 Slot t: inp_west lane i = A[i][t-i] if 0 <= t-i < SIZE else 0.
REQ-024 Slot t: inp_north lane j = B[t-j][j] if 0 <= t-j < SIZE else 0.
REQ-025 feed_valid SHALL be 1 for exactly the 3*SIZE slot cycles of a stream, 0 otherwise.
REQ-026 feed_done SHALL be 1 for exactly one cycle, the cycle after the final slot (DONE state); inp_west/inp_north SHALL be 0 then.
REQ-027 Outside STREAM, inp_west and inp_north SHALL be all zeros.
REQ-028 start during STREAM or DONE SHALL be ignored; no restart, no counter change.
REQ-029 Buffers SHALL retain contents across streams; back-to-back starts SHALL replay identical data.
REQ-030 No arithmetic on data; elements pass unmodified, DATA_WIDTH bits.

Reset
REQ-031 rst low SHALL immediately force IDLE, t=0, buffers all zero, busy=0, feed_valid=0, feed_done=0, inp_west=0, inp_north=0, wr_ready=1.
REQ-032 rst asserted mid-stream SHALL abort the stream with no feed_done pulse; after release, start with no new writes SHALL stream all zeros.

Verification
REQ-033 Reset: rst low at arbitrary time -> all outputs zero, wr_ready=1 within same cycle, busy=0.
REQ-034 Load A[i][j]=i*6+j+1, B[i][j]=(i+1)*(j+1) (SIZE=6), pulse start -> slot 0: west lane0=1, others 0, north lane0=1; slot 5: west lane0=6, lane5=31, north lane0=6, lane5=6; slot 10: west lane5=36, north lane5=36; slots 11..17 all zero; feed_valid high 18 cycles; feed_done one cycle after slot 17.
REQ-035 During stream: assert start and wr_valid (wr_sel=0,wr_row=0,data=all 99) -> wr_ready=0, stream unchanged, replay start afterwards reproduces REQ-034 values.
REQ-036 Write wr_row=7 (invalid for SIZE=6) -> buffers unchanged; same-cycle write row 0 of A = all 50 plus start -> slot 0 west lane0=50.
REQ-037 rst low at slot 7 -> outputs zero immediately, no feed_done; after release, start -> 18 slots of all-zero data, feed_done pulses once.
